ifetch_unit: RTL

//  Instruction-fetch front end: producer side of the raw-instruction interface consumed by decode.

---
 rtl/ifetch_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: one outstanding bus request, small PC/instr FIFO toward decode.
// Optional perf counters (perf_fetched/perf_flushed) are compiled in with `define IFETCH_PERF_EN.
module ifetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ibus_valid,
  output logic [63:0] ibus_addr,
  input  logic        ibus_addr_ok,
  input  logic        ibus_data_ok,
  input  logic [31:0] ibus_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
`ifdef IFETCH_PERF_EN
  ,
  output logic [63:0] perf_fetched,
  output logic [63:0] perf_flushed
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_ADDR = 2'd1;
  localparam logic [1:0] S_WAIT_DATA = 2'd2;
  localparam logic [1:0] S_DISCARD   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [63:0]      addr_q, addr_d;
  logic [63:0]      req_pc_q, req_pc_d;
  logic             pend_q, pend_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [63:0]      pc_mem [BUF_DEPTH];
  logic [31:0]      instr_mem [BUF_DEPTH];

  logic        push, drop, pop;
  logic [63:0] push_pc;

  assign ibus_valid = (state_q == S_WAIT_ADDR);
  assign ibus_addr  = addr_q;
  assign out_valid  = (count_q != '0);
  assign out_pc     = out_valid ? pc_mem[rd_ptr_q]    : '0;
  assign out_instr  = out_valid ? instr_mem[rd_ptr_q] : '0;
  // A redirect flushes the FIFO, so a pop in that cycle is moot.
  assign pop        = out_valid && out_ready && !redirect_valid;
  assign push_pc    = (state_q == S_WAIT_DATA) ? req_pc_q : addr_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    req_pc_d = req_pc_q;
    pend_d   = pend_q;
    push     = 1'b0;
    drop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!redirect_valid && (count_q < CNT_W'(BUF_DEPTH))) begin
          state_d = S_WAIT_ADDR;
          addr_d  = pc_q;
        end
      end
      S_WAIT_ADDR: begin
        if (ibus_addr_ok) begin
          pend_d = 1'b0;
          // A request accepted after a redirect is stale: drop its data, keep the new pc.
          if (redirect_valid || pend_q) begin
            if (ibus_data_ok) begin
              drop    = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_DISCARD;
            end
          end else begin
            pc_d     = addr_q + 64'd4;
            req_pc_d = addr_q;
            if (ibus_data_ok) begin
              push    = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_WAIT_DATA;
            end
          end
        end else if (redirect_valid) begin
          pend_d = 1'b1;
        end
      end
      S_WAIT_DATA: begin
        if (ibus_data_ok) begin
          push    = !redirect_valid;
          drop    = redirect_valid;
          state_d = S_IDLE;
        end else if (redirect_valid) begin
          state_d = S_DISCARD;
        end
      end
      default: begin
        if (ibus_data_ok) begin
          drop    = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
    if (redirect_valid) pc_d = redirect_pc & ~64'h3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      req_pc_q <= RESET_PC;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_pc_q <= req_pc_d;
      pend_q   <= pend_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_valid) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is data-only; visibility is governed by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= push_pc;
      instr_mem[wr_ptr_q] <= ibus_data;
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= perf_fetched + 64'(push);
      perf_flushed <= perf_flushed + 64'(drop) + (redirect_valid ? 64'(count_q) : 64'd0);
    end
  end
`endif

endmodule
